// File: rtl/shift_reg_pkg.sv
// Shared definitions for the shift-register serial link (PISO transmitter / SIPO receiver).
// State encodings, bit-order selectors and a counter sizing helper.
package shift_reg_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RECV = 1'b1
   } state_t;

   localparam bit LSB_FIRST_MODE = 1'b1;
   localparam bit MSB_FIRST_MODE = 1'b0;

   // A counter for a one-bit word still needs a one-bit register.
   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/sipo_rx_if.sv
// Serial input and parallel word handshake bundle of the SIPO receiver.
// The receiver takes the slave side; the transmitter/consumer pair takes the master side.
interface sipo_rx_if #(
   parameter int WIDTH = 4
);
   logic             si_valid;
   logic             si;
   logic             frm_start;
   logic             po_ready;
   logic [WIDTH-1:0] po;
   logic             po_valid;

   modport master (
      output si_valid, si, frm_start, po_ready,
      input  po, po_valid
   );

   modport slave (
      input  si_valid, si, frm_start, po_ready,
      output po, po_valid
   );
endinterface

// File: rtl/sipo_out_stage.sv
// Parallel output holding register with valid/ready handshake and sticky overrun flag.
// A completed word replaces the held one only if the slot is empty or being consumed.
module sipo_out_stage #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             done,
   input  logic [WIDTH-1:0] word,
   input  logic             po_ready,
   input  logic             clr_err,
   output logic [WIDTH-1:0] po,
   output logic             po_valid,
   output logic             overrun
);

   logic accept;
   logic drop;

   always_comb begin
      accept = done && (!po_valid || po_ready);
      drop   = done && po_valid && !po_ready;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         po       <= '0;
         po_valid <= 1'b0;
      end else if (accept) begin
         po       <= word;
         po_valid <= 1'b1;
      end else if (po_valid && po_ready) begin
         po_valid <= 1'b0;
      end
   end

   // A drop on the same edge as a clear must stay visible.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overrun <= 1'b0;
      end else if (drop) begin
         overrun <= 1'b1;
      end else if (clr_err) begin
         overrun <= 1'b0;
      end
   end

endmodule

// File: rtl/sipo_rx.sv
// Serial-in/parallel-out receiver: framed bit stream in, WIDTH-bit words out.
// FSM, bit counter, shift register and framing-error flag live here; output handshake is in sipo_out_stage.
module sipo_rx
   import shift_reg_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter bit LSB_FIRST = LSB_FIRST_MODE
) (
   input  logic             clk,
   input  logic             rst,
   sipo_rx_if.slave         bus,
   input  logic             clr_err,
   output logic [WIDTH-1:0] sreg,
   output logic             busy,
   output logic             overrun,
   output logic             frm_err
);

   localparam int                 CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0]   LAST  = CNT_W'(WIDTH - 1);

   // Either order leaves the transmitted word in sreg after WIDTH shifts.
   function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur, input logic b);
      logic [WIDTH-1:0] r;
      r = cur;
      if (LSB_FIRST == LSB_FIRST_MODE) begin
         for (int i = 0; i < WIDTH - 1; i++) r[i] = cur[i+1];
         r[WIDTH-1] = b;
      end else begin
         for (int i = WIDTH - 1; i > 0; i--) r[i] = cur[i-1];
         r[0] = b;
      end
      return r;
   endfunction

   state_t           state;
   state_t           state_n;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_n;
   logic [WIDTH-1:0] sreg_n;
   logic             shift_en;
   logic             done;
   logic             ferr_set;

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      done     = 1'b0;
      ferr_set = 1'b0;
      shift_en = bus.si_valid && (bus.frm_start || state == RECV);
      sreg_n   = shift_in(sreg, bus.si);

      if (bus.si_valid && bus.frm_start) begin
         // A new frame marker always restarts the word; cutting one short is an error.
         ferr_set = (state == RECV);
         if (WIDTH == 1) begin
            done    = 1'b1;
            state_n = IDLE;
            cnt_n   = '0;
         end else begin
            state_n = RECV;
            cnt_n   = CNT_W'(1);
         end
      end else if (bus.si_valid && state == RECV) begin
         if (cnt == LAST) begin
            done    = 1'b1;
            state_n = IDLE;
            cnt_n   = '0;
         end else begin
            cnt_n = cnt + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sreg <= '0;
      end else if (shift_en) begin
         sreg <= sreg_n;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         frm_err <= 1'b0;
      end else if (ferr_set) begin
         frm_err <= 1'b1;
      end else if (clr_err) begin
         frm_err <= 1'b0;
      end
   end

   assign busy = (state == RECV);

   // The completed word includes the bit sampled on this edge, hence sreg_n.
   sipo_out_stage #(
      .WIDTH(WIDTH)
   ) u_out (
      .clk     (clk),
      .rst     (rst),
      .done    (done),
      .word    (sreg_n),
      .po_ready(bus.po_ready),
      .clr_err (clr_err),
      .po      (bus.po),
      .po_valid(bus.po_valid),
      .overrun (overrun)
   );

endmodule

// File: tb/tb_sipo_rx.sv
// Bench for sipo_rx: LSB-first and MSB-first instances share one stimulus stream
// and are compared every cycle against a bit-list reference model.
module tb_sipo_rx;
   localparam int W = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic clr_err = 1'b0;
   logic si_valid = 1'b0, si = 1'b0, frm_start = 1'b0, po_ready = 1'b0;

   always #5 clk = ~clk;

   sipo_rx_if #(.WIDTH(W)) bus_l ();
   sipo_rx_if #(.WIDTH(W)) bus_m ();

   assign bus_l.si_valid = si_valid;
   assign bus_l.si = si;
   assign bus_l.frm_start = frm_start;
   assign bus_l.po_ready = po_ready;
   assign bus_m.si_valid = si_valid;
   assign bus_m.si = si;
   assign bus_m.frm_start = frm_start;
   assign bus_m.po_ready = po_ready;

   logic [W-1:0] sreg_l, sreg_m;
   logic busy_l, busy_m, ovr_l, ovr_m, ferr_l, ferr_m;

   sipo_rx #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_l (
      .clk(clk), .rst(rst), .bus(bus_l), .clr_err(clr_err),
      .sreg(sreg_l), .busy(busy_l), .overrun(ovr_l), .frm_err(ferr_l)
   );

   sipo_rx #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_m (
      .clk(clk), .rst(rst), .bus(bus_m), .clr_err(clr_err),
      .sreg(sreg_m), .busy(busy_m), .overrun(ovr_m), .frm_err(ferr_m)
   );

   int tests = 0;
   int fails = 0;

   // Reference model: bits of the current word in arrival order, plus recent shifted bits.
   bit cur[$];
   bit hist[$];
   logic [W-1:0] m_po_l, m_po_m;
   bit m_pv, m_ovr, m_ferr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] word_of(input bit lsb);
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < W; i++) begin
         if (lsb) r[i] = cur[i];
         else     r[W-1-i] = cur[i];
      end
      return r;
   endfunction

   // k-th most recent shifted bit sits at W-1-k (LSB-first) or at k (MSB-first).
   function automatic logic [W-1:0] sreg_of(input bit lsb);
      logic [W-1:0] r;
      int n;
      r = '0;
      n = hist.size();
      for (int k = 0; k < n; k++) begin
         if (lsb) r[W-1-k] = hist[n-1-k];
         else     r[k] = hist[n-1-k];
      end
      return r;
   endfunction

   task automatic model_reset();
      cur.delete();
      hist.delete();
      m_po_l = '0;
      m_po_m = '0;
      m_pv = 0;
      m_ovr = 0;
      m_ferr = 0;
   endtask

   task automatic model_edge();
      bit done, ovr_set, ferr_set, shifted;
      logic [W-1:0] wl, wm;
      done = 0; ovr_set = 0; ferr_set = 0; shifted = 0;
      wl = '0; wm = '0;
      if (si_valid) begin
         if (frm_start) begin
            if (cur.size() > 0) ferr_set = 1;
            cur.delete();
            shifted = 1;
         end else if (cur.size() > 0) begin
            shifted = 1;
         end
      end
      if (shifted) begin
         cur.push_back(si);
         hist.push_back(si);
         if (hist.size() > W) void'(hist.pop_front());
      end
      if (cur.size() == W) begin
         done = 1;
         wl = word_of(1'b1);
         wm = word_of(1'b0);
         cur.delete();
      end
      if (done) begin
         if (!m_pv || po_ready) begin
            m_po_l = wl;
            m_po_m = wm;
            m_pv = 1;
         end else begin
            ovr_set = 1;
         end
      end else if (m_pv && po_ready) begin
         m_pv = 0;
      end
      if (ovr_set) m_ovr = 1; else if (clr_err) m_ovr = 0;
      if (ferr_set) m_ferr = 1; else if (clr_err) m_ferr = 0;
   endtask

   task automatic check_all();
      chk("po_l", 32'(bus_l.po), 32'(m_po_l));
      chk("po_m", 32'(bus_m.po), 32'(m_po_m));
      chk("po_valid_l", 32'(bus_l.po_valid), 32'(m_pv));
      chk("po_valid_m", 32'(bus_m.po_valid), 32'(m_pv));
      chk("busy_l", 32'(busy_l), 32'(cur.size() > 0));
      chk("busy_m", 32'(busy_m), 32'(cur.size() > 0));
      chk("overrun", 32'({ovr_l, ovr_m}), 32'({m_ovr, m_ovr}));
      chk("frm_err", 32'({ferr_l, ferr_m}), 32'({m_ferr, m_ferr}));
      chk("sreg_l", 32'(sreg_l), 32'(sreg_of(1'b1)));
      chk("sreg_m", 32'(sreg_m), 32'(sreg_of(1'b0)));
   endtask

   task automatic step(input bit v, input bit b, input bit fs, input bit rdy, input bit clr);
      si_valid = v;
      si = b;
      frm_start = fs;
      po_ready = rdy;
      clr_err = clr;
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   // seq[0] is sent first, with frm_start; rdy applies only on the last bit.
   task automatic frame(input logic [W-1:0] seq, input bit rdy);
      for (int i = 0; i < W; i++) step(1'b1, seq[i], i == 0, (i == W - 1) ? rdy : 1'b0, 1'b0);
   endtask

   initial begin
      model_reset();
      #3;
      check_all();
      @(negedge clk);
      rst = 1'b1;

      // Reset in the middle of a word
      step(1, 1, 1, 0, 0);
      step(1, 1, 0, 0, 0);
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      check_all();
      chk("rst_sreg", 32'(sreg_l), 32'h0);
      @(negedge clk);
      rst = 1'b1;
      frame(4'b1001, 0);
      chk("rst_after_po", 32'(bus_l.po), 32'h9);
      chk("rst_after_flags", 32'({ovr_l, ferr_l}), 32'h0);
      step(0, 0, 0, 1, 0);
      chk("consume_pv", 32'(bus_l.po_valid), 32'h0);

      // Basic LSB-first word 1,0,1,1
      frame(4'b1101, 0);
      chk("basic_lsb_po", 32'(bus_l.po), 32'hD);
      chk("basic_lsb_pv", 32'(bus_l.po_valid), 32'h1);
      step(0, 0, 0, 1, 0);
      chk("basic_pulse_pv", 32'(bus_l.po_valid), 32'h0);

      // MSB-first word 1,1,0,1
      frame(4'b1011, 1);
      chk("msb_po", 32'(bus_m.po), 32'hD);
      step(0, 0, 0, 1, 0);

      // Overrun with consumer stalled, then clear
      frame(4'b1101, 0);
      frame(4'b0000, 0);
      chk("ovr_po", 32'(bus_l.po), 32'hD);
      chk("ovr_flag", 32'(ovr_l), 32'h1);
      step(0, 0, 0, 0, 1);
      chk("ovr_clr", 32'(ovr_l), 32'h0);

      // Consume and complete on the same edge
      frame(4'b0000, 1);
      chk("simul_po", 32'(bus_l.po), 32'h0);
      chk("simul_pv", 32'(bus_l.po_valid), 32'h1);
      chk("simul_ovr", 32'(ovr_l), 32'h0);
      step(0, 0, 0, 1, 0);

      // Short frame, then 1,0,0,1 with stall gaps
      step(1, 1, 1, 0, 0);
      step(1, 0, 0, 0, 0);
      step(1, 1, 1, 0, 0);
      step(0, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      chk("short_ferr", 32'(ferr_l), 32'h1);
      chk("short_po", 32'(bus_l.po), 32'h9);

      // Bits in IDLE without a frame marker must not shift
      step(1, 0, 0, 1, 1);
      step(1, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      chk("idle_sreg", 32'(sreg_l), 32'h9);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         step($urandom_range(0, 4) != 0, 1'($urandom), $urandom_range(0, 5) == 0,
              $urandom_range(0, 2) != 0, $urandom_range(0, 9) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/sipo_rx.md
# sipo_rx

Serial-in/parallel-out word receiver: the receiving end of the parallel-in/serial-out shift-register link. Shifts in a framed serial bit stream, assembles WIDTH-bit words, and presents each word on a registered parallel output with a valid/ready handshake. Sits directly downstream of a PISO transmitter (its `so` drives `si`) and upstream of any word-consuming logic.

## Interface
- `WIDTH`, 4: bits per word; legal range ≥1.
- `LSB_FIRST`, 1: 1 = first received bit is word bit 0 (matches the right-shifting transmitter); 0 = first bit is bit WIDTH-1.
- `clk` input 1: single clock; all state changes on rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `si_valid` input 1: `si` carries a valid bit this cycle.
- `si` input 1: serial data bit.
- `frm_start` input 1: marks the current bit as bit 0 of a new word; sampled only when `si_valid`=1.
- `po_ready` input 1: consumer accepts `po` this cycle.
- `clr_err` input 1: clears `overrun` and `frm_err`.
- `po` output WIDTH: assembled word, held while `po_valid`=1.
- `po_valid` output 1: `po` holds an unconsumed word.
- `sreg` output WIDTH: live shift register contents (debug/observability).
- `busy` output 1: a word is partially received (state RECV).
- `overrun` output 1: sticky; a completed word was dropped.
- `frm_err` output 1: sticky; a word was cut short by `frm_start`.

## Operation
- States: IDLE, RECV. Bit counter `cnt`, range 0..WIDTH-1.
- IDLE: `si_valid` without `frm_start` ignored (no shift). `si_valid`&`frm_start`: shift `si` in, `cnt`←1, go to RECV. With WIDTH=1 this completes the word immediately and stays in IDLE.
- RECV: each `si_valid` shifts one bit, `cnt`+1. The bit taken with `cnt`=WIDTH-1 completes the word: state→IDLE, `cnt`←0.
- Shift: LSB_FIRST=1 → `sreg`←{si, sreg[W-1:1]}; LSB_FIRST=0 → `sreg`←{sreg[W-2:0], si}. After WIDTH shifts, `sreg` equals the transmitted word in both modes.
- `frm_start`&`si_valid` in RECV: partial word discarded, `frm_err`←1, the current bit becomes bit 0 (`cnt`←1, stays RECV).
- Completion with `po_valid`=0, or `po_valid`&`po_ready`: `po`←completed word (including the final bit), `po_valid`←1.
- Completion with `po_valid`=1 & `po_ready`=0: new word dropped, `po` unchanged, `overrun`←1.
- `po_valid`&`po_ready` without completion: `po_valid`←0; `po` keeps its last value.
- `clr_err`: clears both sticky flags; a same-cycle set wins over the clear.
- Reset (any time, including mid-word): `sreg`=0, `po`=0, `po_valid`=0, `cnt`=0, `busy`=0, `overrun`=0, `frm_err`=0, state IDLE. A partial word is lost without a flag.

## Timing
- All outputs registered; no combinational input→output paths.
- Latency: `po_valid` rises on the same edge that samples the last bit (visible the following cycle).
- Back-to-back words (`si_valid` held high, `frm_start` every WIDTH bits) sustain 1 word per WIDTH cycles with zero idle bits, provided `po_ready` is asserted at least once per word.
- A handshake completes on any edge with `po_valid`&`po_ready`.
- `si_valid`=0 cycles inside a word stall reception; there is no timeout.

## Structure
- Shared package `shift_reg_pkg`: state encodings (IDLE, RECV) and the `LSB_FIRST` encoding constants, reused by the PISO transmitter.
- One sub-module, `sipo_out_stage`: `po`/`po_valid` holding register, handshake, and overrun detection. The top level contains the FSM, counter, shift register and `frm_err`.

## Test plan
- Reset mid-word: WIDTH=4, send 2 bits of a frame, pull `rst` low → all outputs 0 immediately. After release, a full frame of 4'b1001 yields `po`=1001 with no flags.
- Basic receive, LSB_FIRST=1: send bits 1,0,1,1 (first with `frm_start`), `po_ready`=0 → `po`=1101 and `po_valid`=1 after the 4th edge. Pulse `po_ready` → `po_valid`=0.
- MSB-first: LSB_FIRST=0, send bits 1,1,0,1 → `po`=1101.
- Overrun: `po_ready` held 0, send 1101 then 0000 back-to-back → `po` stays 1101, `overrun`=1. `clr_err` → `overrun`=0.
- Simultaneous consume and complete: `po_valid`=1, `po_ready`=1 on the edge of 0000's last bit → `po`=0000, `po_valid` stays 1, `overrun`=0.
- Short frame and idle gaps: `frm_start` after 2 bits, then 1,0,0,1 with `si_valid` gaps → `frm_err`=1, `po`=1001. Bits arriving in IDLE without `frm_start` leave `sreg` unchanged.
